// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier for the HI/LO unit: one partial product per cycle,
// signed (MULT) or unsigned (MULTU), full 2*WIDTH-bit result written to HI/LO on completion.
module seq_multiplier #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             MultReset,
  input  logic             MultStart,
  input  logic             MultSigned,
  input  logic [WIDTH-1:0] fatorA,
  input  logic [WIDTH-1:0] fatorB,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             MultBusy,
  output logic             MultDone
);

  localparam int W2 = 2 * WIDTH;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q,  state_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [W2-1:0]    acc_q,    acc_d;
  logic [W2-1:0]    mcand_q,  mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic             signed_q, signed_d;
  logic [WIDTH-1:0] hi_q,     hi_d;
  logic [WIDTH-1:0] lo_q,     lo_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;

  logic [W2-1:0]    partial;
  logic [W2-1:0]    accNext;
  logic             startLoad;

  // The multiplicand is pre-extended to 2*WIDTH bits so that every partial product is already
  // correctly signed. In signed mode the multiplier's MSB carries weight -2^(WIDTH-1), so the
  // final partial product is subtracted instead of added; this keeps min*min exact.
  always_comb begin
    partial   = mplier_q[0] ? mcand_q : '0;
    accNext   = (signed_q && (cnt_q == LAST_ITER)) ? (acc_q - partial) : (acc_q + partial);
    startLoad = MultStart && (state_q != RUN);
  end

  always_ff @(posedge clk) begin
    if (MultReset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      signed_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      signed_q <= signed_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // HI/LO are loaded from the final sum on the same edge that enters DONE, so they jump
  // straight from the previous product to the new one and never expose partial sums.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    signed_d = signed_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    case (state_q)
      RUN: begin
        acc_d    = accNext;
        mcand_d  = {mcand_q[W2-2:0], 1'b0};
        mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_ITER) begin
          hi_d    = accNext[W2-1:WIDTH];
          lo_d    = accNext[WIDTH-1:0];
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // IDLE and DONE accept a new operation identically, which gives back-to-back issue.
    if (startLoad) begin
      mcand_d  = MultSigned ? {{WIDTH{fatorA[WIDTH-1]}}, fatorA} : {{WIDTH{1'b0}}, fatorA};
      mplier_d = fatorB;
      signed_d = MultSigned;
      acc_d    = '0;
      cnt_d    = '0;
      state_d  = RUN;
    end

    busy_d = (state_d == RUN);
  end

  assign HI       = hi_q;
  assign LO       = lo_q;
  assign MultBusy = busy_q;
  assign MultDone = done_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed self-checking bench for seq_multiplier: a 32-bit instance for the main cases and an
// 8-bit instance for the parameter check; expected values are hand-computed constants.
module tb_seq_multiplier;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic        rst32, start32, sgn32, busy32, done32;
  logic [31:0] a32, b32, hi32, lo32;
  logic        rst8, start8, sgn8, busy8, done8;
  logic [7:0]  a8, b8, hi8, lo8;

  int edges;
  int pulses;
  logic [63:0] capture;

  seq_multiplier #(.WIDTH(32)) dut32 (
    .clk(clk), .MultReset(rst32), .MultStart(start32), .MultSigned(sgn32),
    .fatorA(a32), .fatorB(b32), .HI(hi32), .LO(lo32),
    .MultBusy(busy32), .MultDone(done32)
  );

  seq_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .MultReset(rst8), .MultStart(start8), .MultSigned(sgn8),
    .fatorA(a8), .fatorB(b8), .HI(hi8), .LO(lo8),
    .MultBusy(busy8), .MultDone(done8)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one start cycle, scrambles the operand inputs afterwards, and counts edges from
  // the drive point until MultDone is seen (bounded).
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic s,
                               output int nEdges);
    a32 = a; b32 = b; sgn32 = s; start32 = 1'b1;
    tick();
    start32 = 1'b0; a32 = $urandom; b32 = $urandom; sgn32 = ~s;
    nEdges = 1;
    while (done32 !== 1'b1 && nEdges < 100) begin
      tick();
      nEdges++;
    end
  endtask

  task automatic applyStimulus8(input logic [7:0] a, input logic [7:0] b, input logic s,
                                output int nEdges);
    a8 = a; b8 = b; sgn8 = s; start8 = 1'b1;
    tick();
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); sgn8 = ~s;
    nEdges = 1;
    while (done8 !== 1'b1 && nEdges < 100) begin
      tick();
      nEdges++;
    end
  endtask

  initial begin
    rst32 = 1'b1; start32 = 1'b0; sgn32 = 1'b0; a32 = '0; b32 = '0;
    rst8  = 1'b1; start8  = 1'b0; sgn8  = 1'b0; a8  = '0; b8  = '0;
    repeat (2) tick();
    rst32 = 1'b0; rst8 = 1'b0;

    // Reset state
    checkOutput("reset_hilo", {hi32, lo32}, 64'h0);
    checkOutput("reset_busy", 64'(busy32), 64'h0);
    checkOutput("reset_done", 64'(done32), 64'h0);

    // Unsigned max x max
    applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, edges);
    checkOutput("umax_latency", 64'(edges), 64'd33);
    checkOutput("umax_result", {hi32, lo32}, 64'hFFFF_FFFE_0000_0001);
    checkOutput("umax_busy_in_done", 64'(busy32), 64'h0);
    tick();
    checkOutput("done_one_cycle", 64'(done32), 64'h0);
    repeat (3) tick();
    checkOutput("umax_hold", {hi32, lo32}, 64'hFFFF_FFFE_0000_0001);

    // Reset for two cycles mid-RUN aborts and clears HI/LO
    a32 = 32'd3; b32 = 32'd4; sgn32 = 1'b0; start32 = 1'b1;
    tick();
    start32 = 1'b0;
    repeat (10) tick();
    checkOutput("midrun_busy", 64'(busy32), 64'h1);
    rst32 = 1'b1;
    repeat (2) tick();
    rst32 = 1'b0;
    checkOutput("abort_hilo", {hi32, lo32}, 64'h0);
    checkOutput("abort_busy", 64'(busy32), 64'h0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (done32 === 1'b1) pulses++;
      tick();
    end
    checkOutput("abort_no_done", 64'(pulses), 64'h0);

    // Reset and start together: start is dropped
    rst32 = 1'b1; start32 = 1'b1; a32 = 32'd5; b32 = 32'd5;
    tick();
    rst32 = 1'b0; start32 = 1'b0;
    tick();
    checkOutput("rst_start_busy", 64'(busy32), 64'h0);

    // Signed cases
    applyStimulus(32'hFFFF_FFFD, 32'd7, 1'b1, edges);
    checkOutput("s_neg3x7_latency", 64'(edges), 64'd33);
    checkOutput("s_neg3x7", {hi32, lo32}, 64'hFFFF_FFFF_FFFF_FFEB);
    tick();
    applyStimulus(32'h8000_0000, 32'h8000_0000, 1'b1, edges);
    checkOutput("s_minxmin", {hi32, lo32}, 64'h4000_0000_0000_0000);
    tick();

    // Start pulsed while busy is ignored
    a32 = 32'd3; b32 = 32'd4; sgn32 = 1'b0; start32 = 1'b1;
    tick();
    start32 = 1'b0;
    repeat (5) tick();
    a32 = 32'd5; b32 = 32'd5; start32 = 1'b1;
    tick();
    start32 = 1'b0;
    pulses = 0;
    capture = '0;
    for (int i = 0; i < 60; i++) begin
      if (done32 === 1'b1) begin
        pulses++;
        capture = {hi32, lo32};
      end
      tick();
    end
    checkOutput("busy_ignore_result", capture, 64'd12);
    checkOutput("busy_ignore_pulses", 64'(pulses), 64'd1);

    // Back-to-back: issue in the DONE cycle of the previous op
    applyStimulus(32'd3, 32'd4, 1'b0, edges);
    checkOutput("b2b_first_done", 64'(done32), 64'h1);
    checkOutput("b2b_first_result", {hi32, lo32}, 64'd12);
    applyStimulus(32'd2, 32'd9, 1'b0, edges);
    checkOutput("b2b_latency", 64'(edges), 64'd33);
    checkOutput("b2b_result", {hi32, lo32}, 64'd18);

    // WIDTH=8 instance
    checkOutput("w8_reset", {48'h0, hi8, lo8}, 64'h0);
    applyStimulus8(8'h80, 8'hFF, 1'b1, edges);
    checkOutput("w8_latency", 64'(edges), 64'd9);
    checkOutput("w8_signed", {48'h0, hi8, lo8}, 64'h0080);
    checkOutput("w8_busy_in_done", 64'(busy8), 64'h0);
    tick();
    applyStimulus8(8'h80, 8'hFF, 1'b0, edges);
    checkOutput("w8_unsigned_latency", 64'(edges), 64'd9);
    checkOutput("w8_unsigned", {48'h0, hi8, lo8}, 64'h7F80);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
